vfu_result_wb_arbiter: RTL and testbench
========================================

// Module: vfu_result_wb_arbiter
// PURPOSE
//  Responder side of the per-lane FU result write-back handshake (req/gnt). Arbitrates ALU and MFPU
//  result requests onto the lane's single VRF write port through a 1-entry registered output stage.
//  Round-robin between FUs; gnt is returned only when a result is captured. Sits between the FU stage
//  and the VRF bank write interface.
// PARAMETERS
//  NrLanes    0                 lanes in the system (for consistency with lane modules; unused in logic)
//  vaddr_t    logic             VRF element address type
//  DataWidth  $bits(elen_t)     write data width (DO NOT CHANGE)
//  strb_t     [DataWidth/8-1:0] byte-enable type (DO NOT CHANGE)
//  StatWidth  16                width of optional statistic counters
// PORTS
//  clk_i                input   1          clock, all state on rising edge
//  rst_i                input   1          asynchronous reset, active-high
//  alu_result_req_i     input   1          ALU write request, held until gnt
//  alu_result_id_i      input   vid_t      ALU instruction id
//  alu_result_addr_i    input   vaddr_t    ALU write address
//  alu_result_wdata_i   input   DataWidth  ALU write data
//  alu_result_be_i      input   strb_t     ALU byte enables
//  alu_result_gnt_o     output  1          ALU request captured this cycle
//  mfpu_result_*_i / mfpu_result_gnt_o     same set for the MFPU
//  vrf_req_o            output  1          output register holds a valid write
//  vrf_id_o             output  vid_t      id of held write
//  vrf_addr_o           output  vaddr_t    address of held write
//  vrf_wdata_o          output  DataWidth  data of held write
//  vrf_be_o             output  strb_t     byte enables of held write
//  vrf_gnt_i            input   1          VRF consumed the held write this cycle
//  alu_wb_cnt_o         output  StatWidth  accepted ALU writes (only with VFU_WB_STATS_EN)
//  mfpu_wb_cnt_o        output  StatWidth  accepted MFPU writes (only with VFU_WB_STATS_EN)
//  conflict_cnt_o       output  StatWidth  cycles with both req and one denied (only with VFU_WB_STATS_EN)
// BEHAVIOUR
//  - Reset: vrf_req_o=0; vrf_id/addr/wdata/be=0; both gnt=0; rr pointer = ALU; all counters=0.
//    Reset mid-transfer drops the held write; FUs re-present their requests after reset.
//  - Output register: states EMPTY (vrf_req_o=0) and FULL (vrf_req_o=1).
//    can_accept = EMPTY | (FULL & vrf_gnt_i): zero-bubble back-to-back writes.
//  - Arbitration (comb), only when can_accept:
//    one req -> that FU wins; both reqs -> FU selected by rr pointer wins.
//    Winner's gnt_o=1 for exactly that cycle; its fields are registered next edge; state -> FULL.
//    rr pointer updates only on a grant made while both requested, to point at the loser.
//    A lone grant leaves the pointer unchanged.
//  - Transitions:
//    FULL & vrf_gnt_i & no grant -> EMPTY.
//    FULL & !vrf_gnt_i -> hold all vrf_* stable; both gnt_o=0.
//  - gnt_o is never asserted without the matching req_i in the same cycle.
//    Never asserted for both FUs in one cycle.
//  - Latency: request to vrf_req_o = 1 cycle. Throughput: 1 write/cycle while vrf_gnt_i=1.
//  - vrf_gnt_i while EMPTY is ignored.
//    Requester fields are sampled only on their own gnt; no combinational path from req_i to vrf_*.
// CONFIGURATION
//  VFU_WB_STATS_EN defined:
//    alu_wb_cnt_o / mfpu_wb_cnt_o +1 on each respective gnt_o.
//    conflict_cnt_o +1 each cycle both req_i=1 and exactly one gnt_o=1.
//    All saturate at 2**StatWidth-1 (no wrap). Reset to 0.
//  Not defined: the three counter ports are tied to 0 and carry no flops.
//    Arbitration behaviour is identical in both builds.
// TESTING
//  1. ALU req only, addr=0x12, wdata=0xDEADBEEF, be=0xFF, vrf_gnt_i=1
//     -> alu_gnt_o same cycle; next cycle vrf_req_o=1 with those fields.
//  2. Both req held 6 cycles, vrf_gnt_i=1
//     -> grants alternate ALU,MFPU,ALU,MFPU,ALU,MFPU; never both in one cycle.
//  3. ALU write held, vrf_gnt_i=0 for 4 cycles, MFPU requesting
//     -> vrf_* stable, no gnt; on vrf_gnt_i=1 MFPU granted same cycle, no bubble.
//  4. Reset asserted while FULL and both requesting
//     -> vrf_req_o=0 and gnts=0 immediately (async); pointer = ALU.
//     After release ALU wins first.
//  5. VFU_WB_STATS_EN, StatWidth=4, 20 ALU-only accepted writes
//     -> alu_wb_cnt_o=15 (saturated), mfpu_wb_cnt_o=0, conflict_cnt_o=0.
//  6. Build without VFU_WB_STATS_EN, rerun 2
//     -> identical grant sequence; counter ports constantly 0.

Source files
------------

// File: rtl/vfu_result_wb_arbiter.sv
// vfu_result_wb_arbiter
//   Purpose : per-lane write-back responder. Round-robin arbitration of ALU and MFPU
//             result requests (req/gnt) onto the single VRF write port. The winner is
//             captured into a 1-entry output register.
//   Latency : 1 cycle from an accepted request to vrf_req_o. Back-to-back writes have no
//             bubble, so throughput is 1 write per cycle while vrf_gnt_i=1.
//   Backpr. : while the output register is full and vrf_gnt_i=0, no FU is granted and
//             all vrf_* outputs hold stable.
//   Ports   : clk_i / rst_i                  clock; asynchronous active-high reset
//             alu_result_*_i / _gnt_o        ALU request: id, addr, wdata, be, plus its grant
//             mfpu_result_*_i / _gnt_o       MFPU request: same set
//             vrf_*_o / vrf_gnt_i            registered VRF write and its consume strobe
//             *_cnt_o                        saturating statistics counters
//   Config  : define VFU_WB_STATS_EN to build the statistics counters. Without it, the
//             three counter ports are tied to 0 and carry no flops.
module vfu_result_wb_arbiter #(
  parameter int unsigned NrLanes   = 0,
  parameter type         vaddr_t   = logic,
  parameter type         vid_t     = logic,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StatWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // ALU result request
  input  logic                   alu_result_req_i,
  input  vid_t                   alu_result_id_i,
  input  vaddr_t                 alu_result_addr_i,
  input  logic [DataWidth-1:0]   alu_result_wdata_i,
  input  logic [DataWidth/8-1:0] alu_result_be_i,
  output logic                   alu_result_gnt_o,
  // MFPU result request
  input  logic                   mfpu_result_req_i,
  input  vid_t                   mfpu_result_id_i,
  input  vaddr_t                 mfpu_result_addr_i,
  input  logic [DataWidth-1:0]   mfpu_result_wdata_i,
  input  logic [DataWidth/8-1:0] mfpu_result_be_i,
  output logic                   mfpu_result_gnt_o,
  // VRF write port
  output logic                   vrf_req_o,
  output vid_t                   vrf_id_o,
  output vaddr_t                 vrf_addr_o,
  output logic [DataWidth-1:0]   vrf_wdata_o,
  output logic [DataWidth/8-1:0] vrf_be_o,
  input  logic                   vrf_gnt_i,
  // Statistics
  output logic [StatWidth-1:0]   alu_wb_cnt_o,
  output logic [StatWidth-1:0]   mfpu_wb_cnt_o,
  output logic [StatWidth-1:0]   conflict_cnt_o
);

  // Elaboration-time parameter sanity check. The lane count is carried only for
  // consistency with the other lane modules.
  if ((DataWidth % 8) != 0 || DataWidth == 0 || StatWidth == 0 || NrLanes > 1024) begin : g_param_check
    $error("vfu_result_wb_arbiter: illegal parameter combination");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Round-robin pointer: the FU that wins the next two-way conflict.
  typedef enum logic {
    RR_ALU  = 1'b0,
    RR_MFPU = 1'b1
  } rr_e;

  state_e                 state_q, state_d;
  rr_e                    rr_q, rr_d;
  vid_t                   id_q, id_d;
  vaddr_t                 addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] be_q, be_d;

  logic can_accept;
  logic both_req;
  logic alu_gnt, mfpu_gnt;

  // The register can take a new write when empty, or when full and the VRF drains it
  // in the same cycle.
  assign can_accept = (state_q == EMPTY) || vrf_gnt_i;
  assign both_req   = alu_result_req_i && mfpu_result_req_i;

  // Arbitration. Grants are gated by rst_i so that they drop immediately when reset
  // asserts, together with the asynchronously cleared state.
  always_comb begin
    alu_gnt  = 1'b0;
    mfpu_gnt = 1'b0;
    if (can_accept && !rst_i) begin
      if (alu_result_req_i && (!mfpu_result_req_i || rr_q == RR_ALU)) begin
        alu_gnt = 1'b1;
      end else if (mfpu_result_req_i) begin
        mfpu_gnt = 1'b1;
      end
    end
  end

  assign alu_result_gnt_o  = alu_gnt;
  assign mfpu_result_gnt_o = mfpu_gnt;

  // Next state. The fields are loaded only from the granted FU, so no request input
  // reaches the vrf_* outputs combinationally.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;

    if (alu_gnt) begin
      id_d    = alu_result_id_i;
      addr_d  = alu_result_addr_i;
      wdata_d = alu_result_wdata_i;
      be_d    = alu_result_be_i;
    end else if (mfpu_gnt) begin
      id_d    = mfpu_result_id_i;
      addr_d  = mfpu_result_addr_i;
      wdata_d = mfpu_result_wdata_i;
      be_d    = mfpu_result_be_i;
    end

    if (alu_gnt || mfpu_gnt) begin
      state_d = FULL;
    end else if (state_q == FULL && vrf_gnt_i) begin
      state_d = EMPTY;
    end

    // Only a contested grant moves the pointer, and it moves to the loser. A grant to
    // a lone requester leaves the pointer unchanged.
    if (both_req && alu_gnt) begin
      rr_d = RR_MFPU;
    end else if (both_req && mfpu_gnt) begin
      rr_d = RR_ALU;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      rr_q    <= RR_ALU;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign vrf_req_o   = (state_q == FULL);
  assign vrf_id_o    = id_q;
  assign vrf_addr_o  = addr_q;
  assign vrf_wdata_o = wdata_q;
  assign vrf_be_o    = be_q;

`ifdef VFU_WB_STATS_EN
  localparam logic [StatWidth-1:0] CntMax = '1;
  localparam logic [StatWidth-1:0] CntOne = StatWidth'(1);

  logic [StatWidth-1:0] alu_cnt_q, alu_cnt_d;
  logic [StatWidth-1:0] mfpu_cnt_q, mfpu_cnt_d;
  logic [StatWidth-1:0] conf_cnt_q, conf_cnt_d;
  logic                 conflict;

  // A conflict cycle is one in which both FUs request and exactly one of them is granted.
  assign conflict = both_req && (alu_gnt ^ mfpu_gnt);

  // The counters saturate at all-ones instead of wrapping.
  always_comb begin
    alu_cnt_d  = alu_cnt_q;
    mfpu_cnt_d = mfpu_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if (alu_gnt && alu_cnt_q != CntMax) begin
      alu_cnt_d = alu_cnt_q + CntOne;
    end
    if (mfpu_gnt && mfpu_cnt_q != CntMax) begin
      mfpu_cnt_d = mfpu_cnt_q + CntOne;
    end
    if (conflict && conf_cnt_q != CntMax) begin
      conf_cnt_d = conf_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_cnt_q  <= '0;
      mfpu_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      alu_cnt_q  <= alu_cnt_d;
      mfpu_cnt_q <= mfpu_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign alu_wb_cnt_o   = alu_cnt_q;
  assign mfpu_wb_cnt_o  = mfpu_cnt_q;
  assign conflict_cnt_o = conf_cnt_q;
`else
  assign alu_wb_cnt_o   = '0;
  assign mfpu_wb_cnt_o  = '0;
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// tb_vfu_result_wb_arbiter
//   Purpose : table-driven arbitration vectors, with a scoreboard of expected VRF writes,
//             plus hand-written sequences for reset and counter saturation.
//   Timing  : inputs are driven 1 time unit after the rising edge; outputs are sampled
//             on the falling edge.
module tb_vfu_result_wb_arbiter;

  localparam int DW = 64;
  localparam int SW = 4;
`ifdef VFU_WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          alu_req = 1'b0, mfpu_req = 1'b0, vrf_gnt = 1'b0;
  logic [2:0]    alu_id = '0, mfpu_id = '0, vrf_id;
  logic [7:0]    alu_addr = '0, mfpu_addr = '0, vrf_addr;
  logic [DW-1:0] alu_wdata = '0, mfpu_wdata = '0, vrf_wdata;
  logic [7:0]    alu_be = '0, mfpu_be = '0, vrf_be;
  logic          alu_gnt, mfpu_gnt, vrf_req;
  logic [SW-1:0] alu_cnt, mfpu_cnt, conf_cnt;

  always #5 clk_i = ~clk_i;

  vfu_result_wb_arbiter #(
    .NrLanes   (4),
    .vaddr_t   (logic [7:0]),
    .vid_t     (logic [2:0]),
    .DataWidth (DW),
    .StatWidth (SW)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .alu_result_req_i    (alu_req),
    .alu_result_id_i     (alu_id),
    .alu_result_addr_i   (alu_addr),
    .alu_result_wdata_i  (alu_wdata),
    .alu_result_be_i     (alu_be),
    .alu_result_gnt_o    (alu_gnt),
    .mfpu_result_req_i   (mfpu_req),
    .mfpu_result_id_i    (mfpu_id),
    .mfpu_result_addr_i  (mfpu_addr),
    .mfpu_result_wdata_i (mfpu_wdata),
    .mfpu_result_be_i    (mfpu_be),
    .mfpu_result_gnt_o   (mfpu_gnt),
    .vrf_req_o           (vrf_req),
    .vrf_id_o            (vrf_id),
    .vrf_addr_o          (vrf_addr),
    .vrf_wdata_o         (vrf_wdata),
    .vrf_be_o            (vrf_be),
    .vrf_gnt_i           (vrf_gnt),
    .alu_wb_cnt_o        (alu_cnt),
    .mfpu_wb_cnt_o       (mfpu_cnt),
    .conflict_cnt_o      (conf_cnt)
  );

  typedef struct {
    logic [2:0]    id;
    logic [7:0]    addr;
    logic [DW-1:0] wdata;
    logic [7:0]    be;
  } wr_t;

  // Inputs ar/mr/vg; expected alu gnt, mfpu gnt and vrf_req in the same cycle.
  typedef struct {
    logic ar, mr, vg;
    logic ea, em, ev;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[24];
  int   n_vec = 0;
  int   n_err = 0;
  int   seq   = 0;

  function automatic wr_t alu_fields(input int k);
    wr_t w;
    w.id    = k[2:0];
    w.addr  = 8'h12 + k[7:0];
    w.wdata = {k[31:0], 32'hDEADBEEF};
    w.be    = 8'hFF ^ k[7:0];
    return w;
  endfunction

  function automatic wr_t mfpu_fields(input int k);
    wr_t w;
    w.id    = ~k[2:0];
    w.addr  = 8'h80 ^ k[7:0];
    w.wdata = {32'hC0FFEE00 ^ k[31:0], ~k[31:0]};
    w.be    = 8'h0F ^ k[7:0];
    return w;
  endfunction

  function automatic vec_t mk(input logic ar, mr, vg, ea, em, ev);
    vec_t v;
    v.ar = ar; v.mr = mr; v.vg = vg; v.ea = ea; v.em = em; v.ev = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cnts(input int ea, input int em, input int ec);
    chk("alu_wb_cnt",   64'(alu_cnt),  STATS ? 64'(ea) : 64'd0);
    chk("mfpu_wb_cnt",  64'(mfpu_cnt), STATS ? 64'(em) : 64'd0);
    chk("conflict_cnt", 64'(conf_cnt), STATS ? 64'(ec) : 64'd0);
  endtask

  // One clock cycle: drive requests with fresh fields, check the grants and the held
  // write, retire the write if it is consumed, and queue this cycle's expected winner.
  task automatic step(input logic ar, mr, vg, ea, em, ev);
    wr_t a, m;
    @(posedge clk_i);
    #1;
    a = alu_fields(seq);
    m = mfpu_fields(seq);
    seq++;
    alu_req  = ar; alu_id  = a.id; alu_addr  = a.addr; alu_wdata  = a.wdata; alu_be  = a.be;
    mfpu_req = mr; mfpu_id = m.id; mfpu_addr = m.addr; mfpu_wdata = m.wdata; mfpu_be = m.be;
    vrf_gnt  = vg;
    @(negedge clk_i);
    chk("alu_gnt",  64'(alu_gnt),  64'(ea));
    chk("mfpu_gnt", 64'(mfpu_gnt), 64'(em));
    chk("vrf_req",  64'(vrf_req),  64'(ev));
    if (ev) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        chk("vrf_id",    64'(vrf_id),    64'(sb[0].id));
        chk("vrf_addr",  64'(vrf_addr),  64'(sb[0].addr));
        chk("vrf_wdata", vrf_wdata,      sb[0].wdata);
        chk("vrf_be",    64'(vrf_be),    64'(sb[0].be));
        if (vg) void'(sb.pop_front());
      end
    end
    if (ea) sb.push_back(a);
    if (em) sb.push_back(m);
  endtask

  initial begin
    // Lone ALU write at addr 0x12 with wdata DEADBEEF, then its drain.
    tbl[0]  = mk(1,0,1, 1,0,0);
    tbl[1]  = mk(0,0,1, 0,0,1);
    // Both requesting for 6 cycles: the grants alternate, starting with ALU.
    tbl[2]  = mk(1,1,1, 1,0,0);
    tbl[3]  = mk(1,1,1, 0,1,1);
    tbl[4]  = mk(1,1,1, 1,0,1);
    tbl[5]  = mk(1,1,1, 0,1,1);
    tbl[6]  = mk(1,1,1, 1,0,1);
    tbl[7]  = mk(1,1,1, 0,1,1);
    tbl[8]  = mk(0,0,1, 0,0,1);
    // ALU write stalled for 4 cycles while MFPU waits; MFPU is granted on the release.
    tbl[9]  = mk(1,0,0, 1,0,0);
    tbl[10] = mk(0,1,0, 0,0,1);
    tbl[11] = mk(0,1,0, 0,0,1);
    tbl[12] = mk(0,1,0, 0,0,1);
    tbl[13] = mk(0,1,0, 0,0,1);
    tbl[14] = mk(0,1,1, 0,1,1);
    tbl[15] = mk(0,0,1, 0,0,1);
    // A VRF gnt while the register is empty is ignored.
    tbl[16] = mk(0,0,0, 0,0,0);
    tbl[17] = mk(0,0,1, 0,0,0);
    // Lone grants leave the pointer at ALU, so the next conflict goes to ALU.
    tbl[18] = mk(1,0,1, 1,0,0);
    tbl[19] = mk(1,1,0, 0,0,1);
    tbl[20] = mk(1,1,1, 1,0,1);
    tbl[21] = mk(1,1,1, 0,1,1);
    tbl[22] = mk(0,0,1, 0,0,1);
    tbl[23] = mk(0,0,0, 0,0,0);

    // Reset state.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_vrf_req",   64'(vrf_req),  64'd0);
    chk("rst_alu_gnt",   64'(alu_gnt),  64'd0);
    chk("rst_mfpu_gnt",  64'(mfpu_gnt), 64'd0);
    chk("rst_vrf_addr",  64'(vrf_addr), 64'd0);
    chk("rst_vrf_wdata", vrf_wdata,     64'd0);
    chk("rst_vrf_be",    64'(vrf_be),   64'd0);
    chk_cnts(0, 0, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].ar, tbl[i].mr, tbl[i].vg, tbl[i].ea, tbl[i].em, tbl[i].ev);
    end
    chk_cnts(7, 5, 8);

    // Reset while full and both requesting. The contested grant first moves the
    // pointer to MFPU; reset must restore it to ALU.
    step(1,1,1, 1,0,0);
    @(posedge clk_i);
    #1 vrf_gnt = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    chk("arst_vrf_req",  64'(vrf_req),  64'd0);
    chk("arst_alu_gnt",  64'(alu_gnt),  64'd0);
    chk("arst_mfpu_gnt", 64'(mfpu_gnt), 64'd0);
    chk("arst_vrf_addr", 64'(vrf_addr), 64'd0);
    chk_cnts(0, 0, 0);
    sb.delete();
    alu_req  = 1'b0;
    mfpu_req = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    step(1,1,1, 1,0,0);
    step(0,0,1, 0,0,1);
    chk_cnts(1, 0, 1);

    // Counter saturation: a pulse of reset, then 20 accepted ALU-only writes.
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    alu_req = 1'b0;
    mfpu_req = 1'b0;
    sb.delete();
    @(negedge clk_i);
    chk("rst2_vrf_req", 64'(vrf_req), 64'd0);
    chk_cnts(0, 0, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, (k > 0));
    end
    step(0,0,1, 0,0,1);
    chk_cnts(15, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
